inv_sub_bytes_seq: RTL and testbench

- Sequential InvSubBytes stage for the AES decryption datapath.
- Accepts a 128-bit state over a valid/ready handshake and substitutes its 16 bytes through LANES parallel inv_sbox instances, LANES bytes per cycle.
- Returns the substituted state over a second valid/ready handshake.
- Sits between the round-key/InvMixColumns path and the next decrypt round; it is the sole consumer of inv_sbox outputs.

---
 rtl/inv_sub_bytes_seq.sv | 133 +++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// rtl/inv_sub_bytes_seq.sv - sequential AES InvSubBytes stage, LANES bytes per cycle
//
// Purpose : accepts a 128-bit AES state, substitutes its 16 bytes through
//           LANES combinational inv_sbox instances (one byte group per cycle)
//           and returns the result over a valid/ready handshake.
// Ports   : clk, rst_n (async, active-low)
//           in_valid/in_ready/in_state   - upstream state handshake
//           out_valid/out_ready/out_state - downstream state handshake
//           busy                          - high while BUSY or DONE
// Macro   : INV_SHIFT_ROWS_EN - apply InvShiftRows to the state on load.
// Byte k of a state occupies bits [8k:8k+7] (bit 8k is the MSB).

module inv_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  localparam logic [0:2047] TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // High nibble selects the row, low nibble the column: a flat byte index.
  assign o_byte = TABLE[{i_byte, 3'b000} +: 8];
endmodule

module inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state,
  output logic         busy
);
  generate
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  localparam int         NGRP = 16 / LANES;
  localparam logic [3:0] LAST = 4'(NGRP - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t       r_state;
  logic [3:0]   r_grp;
  logic [0:127] r_buf;
  logic [0:127] w_load;
  logic [7:0]   w_lane_in  [LANES];
  logic [7:0]   w_lane_out [LANES];

`ifdef INV_SHIFT_ROWS_EN
  // Row r is rotated right by r columns on load.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign w_load[8*(r+4*c) +: 8] = in_state[8*(r+4*((c-r+4)%4)) +: 8];
    end
  end
`else
  assign w_load = in_state;
`endif

  // Lane j works on byte grp*LANES+j of the buffer.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      w_lane_in[j] = r_buf[8*((int'(r_grp)*LANES + j) % 16) +: 8];
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    inv_sbox u_inv_sbox (
      .i_byte (w_lane_in[j]),
      .o_byte (w_lane_out[j])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grp   <= 4'd0;
      r_buf   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_buf   <= w_load;
            r_grp   <= 4'd0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          for (int j = 0; j < LANES; j++) begin
            r_buf[8*((int'(r_grp)*LANES + j) % 16) +: 8] <= w_lane_out[j];
          end
          if (r_grp == LAST) begin
            r_grp   <= 4'd0;
            r_state <= S_DONE;
          end else begin
            r_grp <= r_grp + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_state = r_buf;
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb/tb_inv_sub_bytes_seq.sv - directed self-checking bench for inv_sub_bytes_seq
module tb_inv_sub_bytes_seq;
  logic         clk;
  logic         rst_n;
  logic [4:0]   in_valid;
  logic [4:0]   in_ready;
  logic [4:0]   out_valid;
  logic [4:0]   out_ready;
  logic [4:0]   busy;
  logic [0:127] in_state;
  logic [0:127] out_st [5];

  int n_checks = 0;
  int n_fail   = 0;

  // Instance 0 is LANES=4; instances 1..4 sweep LANES = 1, 2, 8, 16.
  function automatic int lanes_of(input int d);
    case (d)
      0: return 4;
      1: return 1;
      2: return 2;
      3: return 8;
      default: return 16;
    endcase
  endfunction

  for (genvar g = 0; g < 5; g++) begin : g_dut
    inv_sub_bytes_seq #(
      .LANES ((g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : (g == 3) ? 8 : 16)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_st[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one state, wait for acceptance, then count cycles to out_valid.
  task automatic send(input int d, input logic [0:127] s, output int lat);
    in_state    = s;
    in_valid[d] = 1'b1;
    tick();
    in_valid[d] = 1'b0;
    lat = 0;
    while (!out_valid[d] && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain(input int d);
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    check($sformatf("idle_after_drain_%0d", d), in_ready[d], 1'b1);
    check($sformatf("busy_after_drain_%0d", d), busy[d], 1'b0);
  endtask

  localparam logic [0:127] SEQ_IN  = 128'h000102030405060708090a0b0c0d0e0f;
`ifdef INV_SHIFT_ROWS_EN
  localparam logic [0:127] SEQ_EXP = 128'h52f3a3383009d79ebf366afb8140a5d5;
`else
  localparam logic [0:127] SEQ_EXP = 128'h52096ad53036a538bf40a39e81f3d7fb;
`endif

  initial begin
    int           lat;
    int           acc [3];
    int           n_acc;
    logic         prev;
    logic [0:127] held;

    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    in_state  = '0;
    tick();
    tick();
    for (int d = 0; d < 5; d++) begin
      check($sformatf("reset_in_ready_%0d", d), in_ready[d], 1'b1);
      check($sformatf("reset_out_valid_%0d", d), out_valid[d], 1'b0);
      check($sformatf("reset_busy_%0d", d), busy[d], 1'b0);
      check($sformatf("reset_out_state_%0d", d), out_st[d], 128'h0);
    end
    rst_n = 1'b1;
    tick();

    // All-0x63 maps to all-zero in 4 cycles.
    send(0, {16{8'h63}}, lat);
    check("lat_63", lat, 4);
    check("data_63", out_st[0], 128'h0);
    drain(0);

    // Counting bytes, then backpressure with a competing in_valid.
    send(0, SEQ_IN, lat);
    check("lat_seq", lat, 4);
    check("data_seq", out_st[0], SEQ_EXP);
    held        = out_st[0];
    in_state    = {16{8'h11}};
    in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_out_valid", out_valid[0], 1'b1);
      check("bp_in_ready", in_ready[0], 1'b0);
      check("bp_out_state", out_st[0], held);
    end
    in_valid[0] = 1'b0;
    drain(0);

    // Asynchronous reset in the middle of BUSY.
    in_state    = {16{8'h63}};
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick();
    check("pre_rst_busy", busy[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid[0], 1'b0);
    check("rst_in_ready", in_ready[0], 1'b1);
    check("rst_busy", busy[0], 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_out_valid", out_valid[0], 1'b0);
    send(0, {16{8'hff}}, lat);
    check("post_rst_lat", lat, 4);
    check("post_rst_data", out_st[0], {16{8'h7d}});
    drain(0);

    // LANES sweep with all-0xff.
    for (int d = 1; d < 5; d++) begin
      send(d, {16{8'hff}}, lat);
      check($sformatf("sweep_lat_L%0d", lanes_of(d)), lat, 16 / lanes_of(d));
      check($sformatf("sweep_data_L%0d", lanes_of(d)), out_st[d], {16{8'h7d}});
      drain(d);
    end

    // Back-to-back: accept period is latency + 2.
    for (int d = 0; d < 5; d++) begin
      in_state     = {16{8'hff}};
      in_valid[d]  = 1'b1;
      out_ready[d] = 1'b1;
      n_acc        = 0;
      prev         = in_ready[d];
      for (int c = 0; c < 120 && n_acc < 3; c++) begin
        tick();
        if (prev && busy[d]) begin
          acc[n_acc] = c;
          n_acc++;
        end
        prev = in_ready[d];
      end
      in_valid[d] = 1'b0;
      check($sformatf("b2b_count_L%0d", lanes_of(d)), n_acc, 3);
      if (n_acc == 3) begin
        check($sformatf("b2b_period1_L%0d", lanes_of(d)), acc[1] - acc[0], 16 / lanes_of(d) + 2);
        check($sformatf("b2b_period2_L%0d", lanes_of(d)), acc[2] - acc[1], 16 / lanes_of(d) + 2);
      end
      for (int c = 0; c < 20 && busy[d]; c++) tick();
      out_ready[d] = 1'b0;
      check($sformatf("b2b_idle_L%0d", lanes_of(d)), in_ready[d], 1'b1);
      check($sformatf("b2b_data_L%0d", lanes_of(d)), out_st[d], {16{8'h7d}});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
